// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR, IDCODE/BYPASS DRs, AXI-debug select and TDO mux.
// Latency: FSM/IR/DR update on rising tck_i; td_o is registered half a cycle later, on falling tck_i.
// Backpressure: none; the serial protocol is paced entirely by tck_i/tms_i from the probe.
module jtag_tap_ctrl #(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h149511C3,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'b0010,
  parameter logic [IR_WIDTH-1:0] AXIREG_INSTR = 4'b0100,
  parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = 4'b1111
) (
  input  logic tck_i,
  input  logic trst_i,
  input  logic tms_i,
  input  logic td_i,
  output logic td_o,
  input  logic axireg_td_i,
  output logic axireg_sel_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_dr_o,
  output logic tap_reset_o
);

  // Encoding follows the customary 1149.1 state codes so scope traces read naturally.
  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SHIFT_DR = 4'h2,
    EXIT1_DR = 4'h1,
    PAUSE_DR = 4'h3,
    EXIT2_DR = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SHIFT_IR = 4'hA,
    EXIT1_IR = 4'h9,
    PAUSE_IR = 4'hB,
    EXIT2_IR = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  // Fixed pattern captured into the IR shift register: ...01 in the two LSBs.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_shift_q;
  logic [31:0]         idcode_q;
  logic                bypass_q;
  logic                sel_idcode, sel_axireg, sel_bypass;

  // State register; trst_i wins over a coincident tck edge.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) state_q <= TLR;
    else        state_q <= state_d;
  end

  // Next-state decode from TMS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = tms_i ? TLR      : RTI;
      RTI:      state_d = tms_i ? SEL_DR   : RTI;
      SEL_DR:   state_d = tms_i ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms_i ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_d = tms_i ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_d = tms_i ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tms_i ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_d = tms_i ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_d = tms_i ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms_i ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms_i ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_d = tms_i ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_d = tms_i ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tms_i ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_d = tms_i ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_d = tms_i ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  // Active IR: forced to IDCODE on every edge that lands in TLR, so the select drops together with entry to TLR.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i)                 ir_q <= IDCODE_INSTR;
    else if (state_d == TLR)    ir_q <= IDCODE_INSTR;
    else if (state_q == UPD_IR) ir_q <= ir_shift_q;
  end

  // IR shift register: capture fixed pattern, shift LSB-out with td_i entering at the MSB, hold elsewhere.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i)                   ir_shift_q <= '0;
    else if (state_q == CAP_IR)   ir_shift_q <= IR_CAPTURE;
    else if (state_q == SHIFT_IR) ir_shift_q <= {td_i, ir_shift_q[IR_WIDTH-1:1]};
  end

  assign sel_idcode = (ir_q == IDCODE_INSTR);
  assign sel_axireg = (ir_q == AXIREG_INSTR);
  assign sel_bypass = (ir_q == BYPASS_INSTR) || !(sel_idcode || sel_axireg);

  // IDCODE data register, only touched while IDCODE is the selected instruction.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i)                                idcode_q <= '0;
    else if (sel_idcode && state_q == CAP_DR)   idcode_q <= IDCODE_VALUE;
    else if (sel_idcode && state_q == SHIFT_DR) idcode_q <= {td_i, idcode_q[31:1]};
  end

  // Single-bit bypass register for BYPASS and every undefined opcode.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i)                                bypass_q <= 1'b0;
    else if (sel_bypass && state_q == CAP_DR)   bypass_q <= 1'b0;
    else if (sel_bypass && state_q == SHIFT_DR) bypass_q <= td_i;
  end

  // TDO launched on the falling edge from the register feeding the current shift; holds outside shift states.
  always_ff @(negedge tck_i or posedge trst_i) begin
    if (trst_i)                   td_o <= 1'b0;
    else if (state_q == SHIFT_IR) td_o <= ir_shift_q[0];
    else if (state_q == SHIFT_DR) td_o <= sel_axireg ? axireg_td_i :
                                          sel_idcode ? idcode_q[0] : bypass_q;
  end

  assign axireg_sel_o = sel_axireg;
  assign shift_dr_o   = (state_q == SHIFT_DR);
  assign update_dr_o  = (state_q == UPD_DR);
  assign capture_dr_o = (state_q == CAP_DR);
  assign tap_reset_o  = (state_q == TLR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
module tb_jtag_tap_ctrl;

  logic tck = 1'b0;
  logic trst, tms, tdi, tdo, axi_td;
  logic sel, shift_dr, upd_dr, cap_dr, tlr;

  int total = 0;
  int bad   = 0;

  jtag_tap_ctrl dut (
    .tck_i        (tck),
    .trst_i       (trst),
    .tms_i        (tms),
    .td_i         (tdi),
    .td_o         (tdo),
    .axireg_td_i  (axi_td),
    .axireg_sel_o (sel),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (upd_dr),
    .capture_dr_o (cap_dr),
    .tap_reset_o  (tlr)
  );

  always #5 tck = ~tck;

  // Reference model. States numbered: 0 TLR, 1 RTI, 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PsDR,
  // 7 Ex2DR, 8 UpdDR, 9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PsIR, 14 Ex2IR, 15 UpdIR.
  int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int         ms;
  logic [3:0] mir, mir_sh;
  logic       etdo;
  bit         dq[$];          // selected DR as a bit FIFO, front = next bit out
  logic [31:0] idv = 32'h149511C3;

  task automatic model_reset();
    ms = 0; mir = 4'b0010; mir_sh = 4'b0000; etdo = 1'b0; dq.delete();
  endtask

  task automatic model_rise(input logic t_ms, input logic t_d, input logic t_axi);
    int s;
    s = ms;
    ms = t_ms ? nx1[s] : nx0[s];
    if (s == 3 && mir != 4'b0100) begin
      dq.delete();
      if (mir == 4'b0010) for (int i = 0; i < 32; i++) dq.push_back(idv[i]);
      else dq.push_back(1'b0);
    end else if (s == 4 && mir != 4'b0100) begin
      void'(dq.pop_front());
      dq.push_back(t_d);
    end
    if (s == 10) mir_sh = 4'b0001;
    else if (s == 11) mir_sh = {t_d, mir_sh[3:1]};
    if (s == 15) mir = mir_sh;
    if (ms == 0) mir = 4'b0010;
    if (ms == 11) etdo = mir_sh[0];
    else if (ms == 4) etdo = (mir == 4'b0100) ? t_axi : dq[0];
  endtask

  // One tck cycle: drive, rising edge, falling edge; returns just after the falling edge.
  task automatic tick(input logic t_ms, input logic t_d = 1'b0, input logic t_axi = 1'b0);
    tms = t_ms; tdi = t_d; axi_td = t_axi;
    @(posedge tck);
    model_rise(t_ms, t_d, t_axi);
    #1;
    @(negedge tck);
    #1;
  endtask

  // From RTI, load an instruction and return to RTI.
  task automatic load_ir(input logic [3:0] v);
    tick(1); tick(1); tick(0); tick(0);
    for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
    tick(1); tick(0);
  endtask

  task automatic test_reset();
    trst = 1'b0; tms = 1'b1; tdi = 1'b0; axi_td = 1'b0;
    #1 trst = 1'b1;
    #2;
    model_reset();
    if ({tlr, sel, shift_dr, upd_dr, cap_dr, tdo} !== 6'b100000) begin
      bad++; $display("FAIL reset_async: got %b exp 100000", {tlr, sel, shift_dr, upd_dr, cap_dr, tdo});
    end
    total++;
    @(negedge tck); #1;
    trst = 1'b0;
    #1;
    if ({tlr, sel, shift_dr, upd_dr, cap_dr, tdo} !== 6'b100000) begin
      bad++; $display("FAIL reset_release: got %b exp 100000", {tlr, sel, shift_dr, upd_dr, cap_dr, tdo});
    end
    total++;
    tick(0);
    if (tlr !== 1'b0) begin bad++; $display("FAIL rti_after_reset: tap_reset got %b exp 0", tlr); end
    total++;
    // Reset held across a rising edge with TMS=0: reset must win.
    tms = 1'b0; trst = 1'b1;
    @(posedge tck); #1;
    if (tlr !== 1'b1) begin bad++; $display("FAIL reset_wins: tap_reset got %b exp 1", tlr); end
    total++;
    @(negedge tck); #1;
    trst = 1'b0;
    model_reset();
    tick(0);
  endtask

  task automatic test_idcode();
    logic [31:0] got;
    tick(1); tick(0);
    if (cap_dr !== 1'b1) begin bad++; $display("FAIL idcode_capture: got %b exp 1", cap_dr); end
    total++;
    for (int i = 0; i < 32; i++) begin
      tick(0, 1'b0);
      got[i] = tdo;
    end
    if (got !== 32'h149511C3) begin bad++; $display("FAIL idcode_value: got %h exp 149511c3", got); end
    total++;
    for (int i = 0; i < 4; i++) begin
      tick(0, 1'b0);
      if (tdo !== 1'b0) begin bad++; $display("FAIL idcode_trailing_zero %0d: got %b exp 0", i, tdo); end
      total++;
    end
    tick(1); tick(1); tick(0);
  endtask

  task automatic test_ir_axireg();
    logic [3:0] bits, exp_out;
    bits = 4'b0100; exp_out = 4'b0001;   // exp_out[i] is the i-th td_o bit
    tick(1); tick(1); tick(0);
    tick(0);
    for (int i = 0; i < 4; i++) begin
      if (tdo !== exp_out[i]) begin bad++; $display("FAIL ir_capture_out %0d: got %b exp %b", i, tdo, exp_out[i]); end
      total++;
      if (i < 3) tick(0, bits[i]);
    end
    tick(1, bits[3]);
    tick(1);
    if (sel !== 1'b0) begin bad++; $display("FAIL sel_in_upd_ir: got %b exp 0", sel); end
    total++;
    tick(0);
    if (sel !== 1'b1) begin bad++; $display("FAIL sel_after_upd_ir: got %b exp 1", sel); end
    total++;
  endtask

  task automatic test_axireg_dr();
    logic [3:0] av;
    av = 4'b1101;   // driven in order av[0..3] = 1,0,1,1
    tick(1); tick(0);
    if ({cap_dr, shift_dr} !== 2'b10) begin bad++; $display("FAIL axi_capture: got %b exp 10", {cap_dr, shift_dr}); end
    total++;
    for (int i = 0; i < 4; i++) begin
      tick(0, 1'b0, av[i]);
      if ({cap_dr, shift_dr, tdo} !== {2'b01, av[i]}) begin
        bad++; $display("FAIL axi_shift %0d: got %b exp %b", i, {cap_dr, shift_dr, tdo}, {2'b01, av[i]});
      end
      total++;
    end
    tick(1, 1'b0, 1'b0);
    if (tdo !== 1'b1) begin bad++; $display("FAIL axi_hold_exit1: got %b exp 1", tdo); end
    total++;
    tick(1);
    if (upd_dr !== 1'b1) begin bad++; $display("FAIL axi_update: got %b exp 1", upd_dr); end
    total++;
    tick(0);
    if (upd_dr !== 1'b0) begin bad++; $display("FAIL axi_update_one_cycle: got %b exp 0", upd_dr); end
    total++;
  endtask

  task automatic test_bypass();
    logic [3:0] din, dout;
    din = 4'b1101; dout = 4'b1010;   // in 1,0,1,1 -> out 0,1,0,1
    load_ir(4'b1010);
    if (sel !== 1'b0) begin bad++; $display("FAIL bypass_sel: got %b exp 0", sel); end
    total++;
    tick(1); tick(0); tick(0);
    for (int i = 0; i < 4; i++) begin
      if (tdo !== dout[i]) begin bad++; $display("FAIL bypass_out %0d: got %b exp %b", i, tdo, dout[i]); end
      total++;
      tick(i == 3, din[i]);
    end
    tick(1); tick(0);
  endtask

  task automatic test_tlr_escape();
    int n_upd;
    load_ir(4'b0100);
    tick(1); tick(0); tick(0); tick(0, 1'b1, 1'b1);
    n_upd = 0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      if (upd_dr === 1'b1) n_upd++;
      if (k < 5) begin
        if (tlr !== 1'b0) begin bad++; $display("FAIL escape_early_tlr %0d: got %b exp 0", k, tlr); end
        total++;
      end
    end
    if ({tlr, sel} !== 2'b10) begin bad++; $display("FAIL escape_tlr_sel: got %b exp 10", {tlr, sel}); end
    total++;
    if (n_upd != 1) begin bad++; $display("FAIL escape_update_count: got %0d exp 1", n_upd); end
    total++;
    tick(0);
  endtask

  task automatic test_random();
    logic [5:0] exp_v, got_v;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        trst = 1'b1; #2; trst = 1'b0;
        model_reset();
        if ({tlr, tdo} !== 2'b10) begin bad++; $display("FAIL rand_reset %0d: got %b exp 10", n, {tlr, tdo}); end
        total++;
      end
      tick($urandom_range(0, 99) < 40, 1'($urandom), 1'($urandom));
      exp_v = {ms == 0, mir == 4'b0100, ms == 4, ms == 8, ms == 3, etdo};
      got_v = {tlr, sel, shift_dr, upd_dr, cap_dr, tdo};
      if (got_v !== exp_v) begin
        bad++; $display("FAIL rand_cycle %0d: got %b exp %b (tlr,sel,shift,upd,cap,tdo)", n, got_v, exp_v);
      end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_axireg();
    test_axireg_dr();
    test_bypass();
    test_tlr_escape();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller directly upstream of the AXI debug wrapper.
- Decodes TMS into the 16-state TAP FSM and holds the instruction register (IR).
- Implements the IDCODE and BYPASS data registers internally.
- Drives the shift/update/capture strobes, the AXI-debug register select, and a TDO mux that includes the debug module's serial output.

Parameters:
IR_WIDTH, 4, instruction register width (min 2)
IDCODE_VALUE, 32'h149511C3, device ID; bit0 must be 1
IDCODE_INSTR, 4'b0010, opcode selecting IDCODE DR
AXIREG_INSTR, 4'b0100, opcode selecting the AXI debug DR
BYPASS_INSTR, 4'b1111, explicit bypass opcode; every undefined opcode also selects BYPASS

Ports:
tck_i  in  1  JTAG clock; FSM/IR/DR on rising edge, td_o on falling edge
trst_i  in  1  asynchronous active-high reset
tms_i  in  1  test mode select
td_i  in  1  serial data in
td_o  out  1  serial data out
axireg_td_i  in  1  serial out of the AXI debug module
axireg_sel_o  out  1  IR == AXIREG_INSTR
shift_dr_o  out  1  FSM in Shift-DR
update_dr_o  out  1  FSM in Update-DR
capture_dr_o  out  1  FSM in Capture-DR
tap_reset_o  out  1  FSM in Test-Logic-Reset

Behaviour:
- Reset: asynchronous, active-high on trst_i, one clock (tck_i).
- Reset values (trst_i high): state = Test-Logic-Reset, IR = IDCODE_INSTR, IR shift reg = 0, IDCODE DR = 0, bypass bit = 0, td_o = 0.
  - Derived outputs at reset: axireg_sel_o = 0, shift/update/capture_dr_o = 0, tap_reset_o = 1.
- FSM: 16 states, standard transitions on rising tck_i. The TMS value that moves to each successor is given in brackets.
  - TLR: [0] RTI, [1] TLR
  - RTI: [1] SelDR, [0] RTI
  - SelDR: [0] CapDR, [1] SelIR
  - SelIR: [0] CapIR, [1] TLR
  - CapXR: [0] ShiftXR, [1] Exit1XR
  - ShiftXR: [1] Exit1XR, [0] ShiftXR
  - Exit1XR: [0] PauseXR, [1] UpdXR
  - PauseXR: [1] Exit2XR, [0] PauseXR
  - Exit2XR: [0] ShiftXR, [1] UpdXR
  - UpdXR: [0] RTI, [1] SelDR
- Five consecutive TMS=1 edges reach TLR from any state.
- While the FSM is in TLR, IR is forced to IDCODE_INSTR every cycle.
- All strobe/select outputs are combinational decodes of the state/IR registers. No output depends combinationally on tms_i.
- IR path:
  - Capture-IR loads the IR shift reg with {0..0,01}.
  - Shift-IR: right-shift, td_i into MSB.
  - Update-IR: rising edge with state == Update-IR copies the shift reg to IR.
  - Pause/Exit states hold the shift reg.
- DR path, selected by IR:
  - IDCODE: Capture-DR loads IDCODE_VALUE; Shift-DR right-shifts with td_i into bit31.
  - BYPASS (BYPASS_INSTR or any undefined opcode): 1-bit reg; Capture-DR loads 0; Shift-DR loads td_i.
  - AXIREG: no internal DR; data path is the external debug module via axireg_td_i and the strobes.
- Strobes: shift_dr_o, capture_dr_o and update_dr_o pulse for every instruction; the debug module qualifies them with axireg_sel_o.
- td_o:
  - Registered on falling tck_i.
  - In Shift-IR: IR shift reg bit0.
  - In Shift-DR: per IR, one of IDCODE bit0, bypass bit, or axireg_td_i.
  - All other states: hold last value.
  - Half-cycle latency from the rising edge that shifts.
- Async reset mid-shift: immediate return to TLR; partially shifted IR data is discarded.
- Simultaneous trst_i and tck edge: reset wins.

Test Plan:
- Assert trst_i mid-cycle, release -> tap_reset_o=1, axireg_sel_o=0, all strobes 0, td_o=0. TMS=0 for 1 edge -> RTI, tap_reset_o=0.
- From RTI go to Shift-DR with no IR load, shift 32 bits of td_i=0 -> td_o sequence LSB-first equals 0x149511C3, then 0s.
- Go to Shift-IR, shift 4'b0100 (LSB first 0,0,1,0) -> td_o during shift emits 1,0,0,0 (captured 0001). Then Update-IR -> axireg_sel_o=1 from the next edge.
- With IR=AXIREG, enter Shift-DR, toggle axireg_td_i 1,0,1,1:
  - capture_dr_o high exactly one cycle, then shift_dr_o high.
  - td_o mirrors axireg_td_i on each falling edge.
  - update_dr_o high one cycle in Update-DR.
- Load IR=4'b1010 (undefined), shift td_i 1,0,1,1 in Shift-DR -> td_o outputs 0 (captured bypass) followed by 1,0,1, i.e. delayed one tck.
- While in Shift-DR with IR=AXIREG, TMS=1 for 5 edges -> TLR reached on the 5th edge, IR=IDCODE_INSTR, axireg_sel_o=0, no spurious update_dr_o beyond the single Update-DR pass.
